// File: rtl/step_phase_decoder.sv
// Step phase decoder: watches the 8-bit phase bus driven to a stepper motor,
// filters it for stability, and tracks the resulting step position.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   motor_data   asynchronous phase bus (A, B, /A, /B pairs)
//   clr_pos      synchronous clear of pos
//   pos          signed two's-complement step position, wraps modulo 2^POS_W
//   phase_idx    index (0..3) of the last accepted legal pattern
//   dir_out      direction of the last counted step (1 = forward)
//   step_pulse   one-cycle strobe per counted step
//   locked       high while a valid phase reference is held
//   err_skip     one-cycle strobe on a two-phase jump
//   err_illegal  one-cycle strobe when an illegal pattern is accepted
module step_phase_decoder #(
    parameter int unsigned POS_W         = 16,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       motor_data,
    input  logic             clr_pos,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       phase_idx,
    output logic             dir_out,
    output logic             step_pulse,
    output logic             locked,
    output logic             err_skip,
    output logic             err_illegal
);

    localparam int unsigned       CNT_W     = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  ACCEPT_AT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state;
    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       prev;
    logic [CNT_W-1:0] stable_cnt;

    logic       pat_legal_c;
    logic       pat_idle_c;
    logic [1:0] pat_idx_c;
    logic [1:0] delta_c;
    logic       accept_c;
    logic       act_c;
    logic       step_fwd_c;
    logic       step_rev_c;

    // Two-flop synchronizer, one history flop and the stability counter.
    // The counter measures how long prev has matched the newest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            stable_cnt <= '0;
        end else begin
            sync1 <= motor_data;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 != prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    // Pattern decode of the filtered sample.
    always_comb begin
        pat_legal_c = 1'b1;
        pat_idle_c  = 1'b0;
        pat_idx_c   = 2'd0;
        case (prev)
            8'b1000_0001: pat_idx_c = 2'd0;
            8'b0100_0010: pat_idx_c = 2'd1;
            8'b0010_0100: pat_idx_c = 2'd2;
            8'b0001_1000: pat_idx_c = 2'd3;
            8'h00: begin
                pat_legal_c = 1'b0;
                pat_idle_c  = 1'b1;
            end
            default: pat_legal_c = 1'b0;
        endcase
    end

    // prev has been stable for STABLE_CYCLES samples exactly when the
    // counter sits at STABLE_CYCLES-1; the value is accepted once there.
    always_comb begin
        accept_c   = (stable_cnt == ACCEPT_AT);
        act_c      = accept_c && !pat_idle_c;
        delta_c    = pat_idx_c - phase_idx;
        step_fwd_c = act_c && pat_legal_c && (state == LOCKED) && (delta_c == 2'd1);
        step_rev_c = act_c && pat_legal_c && (state == LOCKED) && (delta_c == 2'd3);
    end

    // Lock FSM, strobes and position counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNLOCKED;
            locked      <= 1'b0;
            phase_idx   <= 2'd0;
            dir_out     <= 1'b0;
            step_pulse  <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
            pos         <= '0;
        end else begin
            step_pulse  <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;

            if (act_c) begin
                if (!pat_legal_c) begin
                    err_illegal <= 1'b1;
                    state       <= UNLOCKED;
                    locked      <= 1'b0;
                end else if (state == UNLOCKED) begin
                    phase_idx <= pat_idx_c;
                    state     <= LOCKED;
                    locked    <= 1'b1;
                end else begin
                    phase_idx <= pat_idx_c;
                    case (delta_c)
                        2'd1: begin
                            step_pulse <= 1'b1;
                            dir_out    <= 1'b1;
                        end
                        2'd3: begin
                            step_pulse <= 1'b1;
                            dir_out    <= 1'b0;
                        end
                        2'd2:    err_skip <= 1'b1;
                        default: ;
                    endcase
                end
            end

            // A clear wins over a coincident step; the step is dropped.
            if (clr_pos) begin
                pos <= '0;
            end else if (step_fwd_c) begin
                pos <= pos + POS_W'(1);
            end else if (step_rev_c) begin
                pos <= pos - POS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_phase_decoder.sv
// Testbench for step_phase_decoder: directed scenarios with literal
// expectations, randomized phase traffic against a behavioural model, and a
// wrap-around run on a fast-filter instance.
module tb_step_phase_decoder;

    localparam int unsigned POS_W = 16;
    localparam int unsigned S     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             clr_pos;
    logic [7:0]       motor_data;
    logic [POS_W-1:0] pos;
    logic [1:0]       phase_idx;
    logic             dir_out;
    logic             step_pulse;
    logic             locked;
    logic             err_skip;
    logic             err_illegal;

    step_phase_decoder #(.POS_W(POS_W), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .motor_data (motor_data),
        .clr_pos    (clr_pos),
        .pos        (pos),
        .phase_idx  (phase_idx),
        .dir_out    (dir_out),
        .step_pulse (step_pulse),
        .locked     (locked),
        .err_skip   (err_skip),
        .err_illegal(err_illegal)
    );

    logic        rst2;
    logic        clr2;
    logic [7:0]  md2;
    logic [15:0] pos2;
    logic [1:0]  idx2;
    logic        dir2;
    logic        step2;
    logic        locked2;
    logic        skip2;
    logic        ill2;

    step_phase_decoder #(.POS_W(16), .STABLE_CYCLES(1)) dut_wrap (
        .clk        (clk),
        .rst        (rst2),
        .motor_data (md2),
        .clr_pos    (clr2),
        .pos        (pos2),
        .phase_idx  (idx2),
        .dir_out    (dir2),
        .step_pulse (step2),
        .locked     (locked2),
        .err_skip   (skip2),
        .err_illegal(ill2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        case (i % 4)
            0:       return 8'b1000_0001;
            1:       return 8'b0100_0010;
            2:       return 8'b0010_0100;
            default: return 8'b0001_1000;
        endcase
    endfunction

    // -1 idle, -2 illegal, else the phase index
    function automatic int pat_class(input logic [7:0] v);
        if (v == 8'h00) return -1;
        for (int i = 0; i < 4; i++) begin
            if (pat(i) == v) return i;
        end
        return -2;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int         cyc = 0;
    bit         armed = 1'b0;
    logic [7:0] last_s;
    int         run;
    int         m_pos, m_idx, cls, d;
    bit         m_locked, m_dir, m_step, m_skip, m_ill;
    int         due_q[$];
    logic [7:0] val_q[$];

    always @(posedge clk) begin
        cyc++;
        m_step = 1'b0;
        m_skip = 1'b0;
        m_ill  = 1'b0;
        if (rst) begin
            armed    = 1'b1;
            m_pos    = 0;
            m_idx    = 0;
            m_locked = 1'b0;
            m_dir    = 1'b0;
            last_s   = 8'h00;
            run      = 1000;
            due_q.delete();
            val_q.delete();
        end else if (armed) begin
            // A value held S samples takes effect three edges later.
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                cls = pat_class(val_q[0]);
                void'(due_q.pop_front());
                void'(val_q.pop_front());
                if (cls == -2) begin
                    m_ill    = 1'b1;
                    m_locked = 1'b0;
                end else if (cls >= 0) begin
                    if (!m_locked) begin
                        m_locked = 1'b1;
                    end else begin
                        d = (cls - m_idx + 4) % 4;
                        if (d == 1) begin
                            m_step = 1'b1;
                            m_dir  = 1'b1;
                            m_pos  = (m_pos + 1) % (1 << POS_W);
                        end else if (d == 3) begin
                            m_step = 1'b1;
                            m_dir  = 1'b0;
                            m_pos  = (m_pos - 1 + (1 << POS_W)) % (1 << POS_W);
                        end else if (d == 2) begin
                            m_skip = 1'b1;
                        end
                    end
                    m_idx = cls;
                end
            end
            if (clr_pos) m_pos = 0;
            if (motor_data == last_s) begin
                run++;
            end else begin
                run    = 1;
                last_s = motor_data;
            end
            if (run == S) begin
                due_q.push_back(cyc + 3);
                val_q.push_back(motor_data);
            end
        end
        #1;
        if (armed) begin
            check("m_pos",       32'(pos),         32'(m_pos));
            check("m_phase_idx", 32'(phase_idx),   32'(m_idx));
            check("m_dir_out",   32'(dir_out),     32'(m_dir));
            check("m_step",      32'(step_pulse),  32'(m_step));
            check("m_locked",    32'(locked),      32'(m_locked));
            check("m_err_skip",  32'(err_skip),    32'(m_skip));
            check("m_err_ill",   32'(err_illegal), 32'(m_ill));
            check("strobe_excl", 32'(32'(step_pulse) + 32'(err_skip) + 32'(err_illegal) <= 1), 32'd1);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive v and check the step strobe appears exactly on the 7th edge.
    task automatic step_seg(input logic [7:0] v, input logic exp_dir);
        @(negedge clk);
        motor_data = v;
        repeat (6) tick();
        check("pulse_early", 32'(step_pulse), 32'd0);
        tick();
        check("pulse_at_7", 32'(step_pulse), 32'd1);
        check("pulse_dir",  32'(dir_out),    32'(exp_dir));
        tick();
        check("pulse_single", 32'(step_pulse), 32'd0);
        repeat (2) tick();
    endtask

    int         r, hold, cur;
    logic [7:0] v;
    logic [7:0] rnd;

    initial begin
        rst        = 1'b1;
        clr_pos    = 1'b0;
        motor_data = 8'h00;
        rst2       = 1'b1;
        clr2       = 1'b0;
        md2        = 8'h00;

        repeat (3) tick();
        check("rst_pos",    32'(pos),         32'd0);
        check("rst_locked", 32'(locked),      32'd0);
        check("rst_idx",    32'(phase_idx),   32'd0);
        check("rst_strobe", 32'(step_pulse | err_skip | err_illegal), 32'd0);

        // Lock on phase 0
        @(negedge clk);
        rst        = 1'b0;
        motor_data = 8'h81;
        repeat (6) tick();
        check("lock_early", 32'(locked), 32'd0);
        tick();
        check("lock_at_7",  32'(locked),    32'd1);
        check("lock_idx",   32'(phase_idx), 32'd0);
        check("lock_pos",   32'(pos),       32'd0);
        check("lock_nostb", 32'(step_pulse | err_skip | err_illegal), 32'd0);
        repeat (13) tick();

        // Forward 1,2,3,0,1
        step_seg(8'h42, 1'b1);
        step_seg(8'h24, 1'b1);
        step_seg(8'h18, 1'b1);
        step_seg(8'h81, 1'b1);
        step_seg(8'h42, 1'b1);
        check("fwd_pos", 32'(pos), 32'd5);
        check("fwd_idx", 32'(phase_idx), 32'd1);

        // Reverse 0,3,2
        step_seg(8'h81, 1'b0);
        step_seg(8'h18, 1'b0);
        step_seg(8'h24, 1'b0);
        check("rev_pos", 32'(pos), 32'd2);

        // Two-cycle glitch is filtered out
        @(negedge clk);
        motor_data = 8'h42;
        repeat (2) @(negedge clk);
        motor_data = 8'h24;
        repeat (12) tick();
        check("glitch_pos", 32'(pos),       32'd2);
        check("glitch_idx", 32'(phase_idx), 32'd2);

        // Back to idx 0, then a two-phase jump and an illegal pattern
        step_seg(8'h42, 1'b0);
        step_seg(8'h81, 1'b0);
        check("pre_skip_pos", 32'(pos), 32'd0);
        @(negedge clk);
        motor_data = 8'h24;
        repeat (6) tick();
        check("skip_early", 32'(err_skip), 32'd0);
        tick();
        check("skip_at_7",  32'(err_skip),   32'd1);
        check("skip_pos",   32'(pos),        32'd0);
        check("skip_idx",   32'(phase_idx),  32'd2);
        check("skip_nostep", 32'(step_pulse), 32'd0);
        tick();
        check("skip_single", 32'(err_skip), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        motor_data = 8'hFF;
        repeat (7) tick();
        check("ill_at_7",  32'(err_illegal), 32'd1);
        check("ill_lock",  32'(locked),      32'd0);
        check("ill_idx",   32'(phase_idx),   32'd2);
        tick();
        check("ill_single", 32'(err_illegal), 32'd0);
        repeat (3) tick();

        // Randomized traffic, with occasional clears and mid-stream resets
        cur = 0;
        for (int k = 0; k < 700; k++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                cur = ($urandom_range(0, 1) == 0) ? (cur + 1) % 4 : (cur + 3) % 4;
                v   = pat(cur);
            end else if (r < 65) begin
                cur = $urandom_range(0, 3);
                v   = pat(cur);
            end else if (r < 80) begin
                v = 8'h00;
            end else begin
                rnd = 8'($urandom());
                v   = rnd;
            end
            hold = $urandom_range(1, 10);
            repeat (hold) begin
                @(negedge clk);
                motor_data = v;
                clr_pos    = ($urandom_range(0, 24) == 0);
                rst        = ($urandom_range(0, 399) == 0);
            end
        end
        @(negedge clk);
        rst     = 1'b0;
        clr_pos = 1'b0;
        repeat (12) tick();

        // Wrap-around on the single-sample-filter instance
        @(negedge clk);
        rst2 = 1'b0;
        md2  = 8'h81;
        repeat (6) @(negedge clk);
        check("w_locked", 32'(locked2), 32'd1);
        check("w_pos0",   32'(pos2),    32'd0);
        for (int i = 1; i <= 32767; i++) begin
            @(negedge clk);
            md2 = pat(i);
        end
        repeat (6) @(negedge clk);
        check("w_pos_7fff", 32'(pos2), 32'h7FFF);
        @(negedge clk);
        md2 = pat(0);
        repeat (6) @(negedge clk);
        check("w_pos_8000", 32'(pos2), 32'h8000);
        check("w_dir",      32'(dir2), 32'd1);
        @(negedge clk);
        md2 = pat(1);
        repeat (3) @(negedge clk);
        clr2 = 1'b1;
        @(posedge clk);
        #1;
        check("w_clr_step", 32'(step2), 32'd1);
        check("w_clr_pos",  32'(pos2),  32'd0);
        check("w_clr_idx",  32'(idx2),  32'd1);
        @(negedge clk);
        clr2 = 1'b0;
        check("w_clr_lock", 32'(locked2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
